morse_decoder_param: RTL and testbench

MORSE_DECODER_PARAM -- requirements
Module: morse_decoder_param

---
 rtl/morse_decoder_param.sv | 276 +++++++++++++++++++++++++++
 tb/tb_morse_decoder_param.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder_param.sv
// -----------------------------------------------------------------------------
// morse_decoder_param
//
// Purpose:
//   Decodes a single Morse key into character codes. The key is synchronised
//   into the CLK domain. All timing runs on a slow decode tick produced by a
//   free-running prescaler. A four-state FSM collects dots and dashes into a
//   pattern and emits one code per letter. It emits a single space code once
//   the key has been idle long enough to end a word. Emitted codes are also
//   shifted into a short history register.
//
// Character codes:
//   0 blank, 1-26 A-Z, 27-36 digits 0-9, 37 space, 63 error.
//
// Configuration macro:
//   MORSE_DIGITS_EN - when defined, 5-element patterns decode to digits 27-36.
//                     When undefined, every 5-element pattern emits 63.
//
// Ports:
//   CLK        in   single clock, everything on posedge
//   RST_N      in   synchronous active-low reset
//   button     in   asynchronous key, active-low (0 = pressed)
//   char_valid out  one-CLK pulse when a new code is emitted
//   char_code  out  last emitted code, held until the next emission
//   history    out  6*HIST_DEPTH bits; entry k at [6k+5:6k], entry 0 newest
//   dot_led    out  last completed element was a dot
//   dash_led   out  last completed element was a dash
//   busy       out  a letter is being keyed (PRESS or GAP)
// -----------------------------------------------------------------------------
module morse_decoder_param #(
  parameter int TICK_DIV         = 2500000,
  parameter int DASH_TICKS       = 4,
  parameter int LETTER_GAP_TICKS = 5,
  parameter int WORD_GAP_TICKS   = 12,
  parameter int HIST_DEPTH       = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    button,
  output logic                    char_valid,
  output logic [5:0]              char_code,
  output logic [6*HIST_DEPTH-1:0] history,
  output logic                    dot_led,
  output logic                    dash_led,
  output logic                    busy
);

  localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX = (WORD_GAP_TICKS > DASH_TICKS + 1) ? WORD_GAP_TICKS : DASH_TICKS + 1;
  localparam int CW   = $clog2(CMAX + 1) + 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DASH_LIM   = CW'(DASH_TICKS);
  localparam logic [CW-1:0] LGAP_LIM   = CW'(LETTER_GAP_TICKS);
  localparam logic [CW-1:0] WGAP_LIM   = CW'(WORD_GAP_TICKS);
  localparam logic [5:0]    CODE_SPACE = 6'd37;
  localparam logic [5:0]    CODE_ERR   = 6'd63;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_WGAP
  } state_t;

  state_t          r_state, w_stateNext;
  logic            r_sync1, r_sync2;
  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_pressCnt, w_pressCntNext;
  logic [CW-1:0]   r_gapCnt, w_gapCntNext;
  logic [4:0]      r_pattern, w_patternNext;
  logic [2:0]      r_n, w_nNext;
  logic            r_ovf, w_ovfNext;
  logic            r_charValid;
  logic [5:0]      r_charCode;
  logic [5:0]      r_hist [HIST_DEPTH];
  logic            r_dotLed, r_dashLed;

  logic            w_pressed;
  logic            w_tick;
  logic            w_isDash;
  logic [CW-1:0]   w_pressInc, w_gapInc;
  logic            w_emit;
  logic [5:0]      w_emitCode;
  logic            w_ledUpd;

  // Pattern bit i is element i (first element in bit 0), a dash is 1.
  function automatic logic [5:0] decodeChar(input logic [2:0] n, input logic [4:0] p);
    logic [5:0] c;
    c = CODE_ERR;
    case (n)
      3'd1: c = p[0] ? 6'd20 : 6'd5;
      3'd2: begin
        case (p[1:0])
          2'd0: c = 6'd9;
          2'd1: c = 6'd14;
          2'd2: c = 6'd1;
          default: c = 6'd13;
        endcase
      end
      3'd3: begin
        case (p[2:0])
          3'd0: c = 6'd19;
          3'd1: c = 6'd4;
          3'd2: c = 6'd18;
          3'd3: c = 6'd7;
          3'd4: c = 6'd21;
          3'd5: c = 6'd11;
          3'd6: c = 6'd23;
          default: c = 6'd15;
        endcase
      end
      3'd4: begin
        case (p[3:0])
          4'd0:  c = 6'd8;
          4'd1:  c = 6'd2;
          4'd2:  c = 6'd12;
          4'd3:  c = 6'd26;
          4'd4:  c = 6'd6;
          4'd5:  c = 6'd3;
          4'd6:  c = 6'd16;
          4'd8:  c = 6'd22;
          4'd9:  c = 6'd24;
          4'd11: c = 6'd17;
          4'd13: c = 6'd25;
          4'd14: c = 6'd10;
          default: c = CODE_ERR;
        endcase
      end
`ifdef MORSE_DIGITS_EN
      3'd5: begin
        case (p)
          5'd31: c = 6'd27;
          5'd30: c = 6'd28;
          5'd28: c = 6'd29;
          5'd24: c = 6'd30;
          5'd16: c = 6'd31;
          5'd0:  c = 6'd32;
          5'd1:  c = 6'd33;
          5'd3:  c = 6'd34;
          5'd7:  c = 6'd35;
          5'd15: c = 6'd36;
          default: c = CODE_ERR;
        endcase
      end
`else
      3'd5: c = CODE_ERR;
`endif
      default: c = CODE_ERR;
    endcase
    return c;
  endfunction

  assign w_pressed  = ~r_sync2;
  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_isDash   = (r_pressCnt > DASH_LIM);
  assign w_pressInc = (r_pressCnt == '1) ? r_pressCnt : r_pressCnt + CW'(1);
  assign w_gapInc   = (r_gapCnt == '1) ? r_gapCnt : r_gapCnt + CW'(1);

  // Next-state logic. Nothing moves except on tick cycles. A letter is
  // emitted from GAP. A space can only come from WGAP, and WGAP is reached
  // only after a letter, so a space never follows a space or reset.
  always_comb begin
    w_stateNext    = r_state;
    w_pressCntNext = r_pressCnt;
    w_gapCntNext   = r_gapCnt;
    w_patternNext  = r_pattern;
    w_nNext        = r_n;
    w_ovfNext      = r_ovf;
    w_emit         = 1'b0;
    w_emitCode     = '0;
    w_ledUpd       = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE, S_WGAP: begin
          if (w_pressed) begin
            w_stateNext    = S_PRESS;
            w_pressCntNext = CW'(1);
            w_patternNext  = '0;
            w_nNext        = '0;
            w_ovfNext      = 1'b0;
          end else if (r_state == S_WGAP) begin
            w_gapCntNext = w_gapInc;
            if (w_gapInc >= WGAP_LIM) begin
              w_emit      = 1'b1;
              w_emitCode  = CODE_SPACE;
              w_stateNext = S_IDLE;
            end
          end
        end
        S_PRESS: begin
          if (w_pressed) begin
            w_pressCntNext = w_pressInc;
          end else begin
            w_ledUpd = 1'b1;
            if (r_n < 3'd5) begin
              w_patternNext = r_pattern | (5'(w_isDash) << r_n);
              w_nNext       = r_n + 3'd1;
            end else begin
              w_ovfNext = 1'b1;
            end
            w_gapCntNext = CW'(1);
            w_stateNext  = S_GAP;
          end
        end
        default: begin
          if (w_pressed) begin
            w_stateNext    = S_PRESS;
            w_pressCntNext = CW'(1);
          end else begin
            w_gapCntNext = w_gapInc;
            if (w_gapInc >= LGAP_LIM) begin
              w_emit      = 1'b1;
              w_emitCode  = r_ovf ? CODE_ERR : decodeChar(r_n, r_pattern);
              w_stateNext = S_WGAP;
            end
          end
        end
      endcase
    end
  end

  // Registers. The outputs register the emit decision made on the tick
  // cycle, so char_valid, char_code and history change on the following cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_presc     <= '0;
      r_pressCnt  <= '0;
      r_gapCnt    <= '0;
      r_pattern   <= '0;
      r_n         <= '0;
      r_ovf       <= 1'b0;
      r_charValid <= 1'b0;
      r_charCode  <= '0;
      r_dotLed    <= 1'b0;
      r_dashLed   <= 1'b0;
      for (int k = 0; k < HIST_DEPTH; k++) r_hist[k] <= '0;
    end else begin
      r_sync1     <= button;
      r_sync2     <= r_sync1;
      r_presc     <= w_tick ? '0 : r_presc + PW'(1);
      r_state     <= w_stateNext;
      r_pressCnt  <= w_pressCntNext;
      r_gapCnt    <= w_gapCntNext;
      r_pattern   <= w_patternNext;
      r_n         <= w_nNext;
      r_ovf       <= w_ovfNext;
      r_charValid <= w_emit;
      if (w_emit) begin
        r_charCode <= w_emitCode;
        for (int k = HIST_DEPTH - 1; k > 0; k--) r_hist[k] <= r_hist[k-1];
        r_hist[0] <= w_emitCode;
      end
      if (w_ledUpd) begin
        r_dashLed <= w_isDash;
        r_dotLed  <= ~w_isDash;
      end
    end
  end

  // Pack the history array onto the flat output bus.
  always_comb begin
    history = '0;
    for (int k = 0; k < HIST_DEPTH; k++) history[6*k +: 6] = r_hist[k];
  end

  assign char_valid = r_charValid;
  assign char_code  = r_charCode;
  assign dot_led    = r_dotLed;
  assign dash_led   = r_dashLed;
  assign busy       = (r_state == S_PRESS) || (r_state == S_GAP);

endmodule

// File: tb/tb_morse_decoder_param.sv
// -----------------------------------------------------------------------------
// tb_morse_decoder_param
//
// Purpose:
//   Drives morse_decoder_param with keyed letters, both scripted and random.
//   A reference model works on dot/dash strings and a code table. The bench
//   compares the emitted code stream, the history bus, the LEDs and busy
//   against that model. Honours MORSE_DIGITS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_morse_decoder_param;

  localparam int TICK_DIV = 4;
  localparam int HD       = 8;

`ifdef MORSE_DIGITS_EN
  localparam bit DIGITS = 1'b1;
`else
  localparam bit DIGITS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          button;
  logic          char_valid;
  logic [5:0]    char_code;
  logic [6*HD-1:0] history;
  logic          dot_led, dash_led, busy;

  int total = 0;
  int bad   = 0;

  int obsQ[$];
  int expQ[$];
  int modelHist[$];
  int dblCnt = 0;
  logic prevValid = 1'b0;

  // Index i holds the pattern for code i+1 (A..Z, then 0..9).
  string morseTab [36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----."
  };

  morse_decoder_param #(
    .TICK_DIV(TICK_DIV),
    .DASH_TICKS(4),
    .LETTER_GAP_TICKS(5),
    .WORD_GAP_TICKS(12),
    .HIST_DEPTH(HD)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .button(button),
    .char_valid(char_valid),
    .char_code(char_code),
    .history(history),
    .dot_led(dot_led),
    .dash_led(dash_led),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Collect every emitted code and count pulses longer than one cycle.
  always @(negedge CLK) begin
    if (char_valid) begin
      obsQ.push_back(int'(char_code));
      if (prevValid) dblCnt++;
    end
    prevValid = char_valid;
  end

  function automatic int modelDecode(input string p);
    if (p.len() > 5 || p.len() == 0) return 63;
    for (int i = 0; i < 36; i++) begin
      if (morseTab[i] == p) begin
        if (i >= 26 && !DIGITS) return 63;
        return i + 1;
      end
    end
    return 63;
  endfunction

  function automatic void modelEmit(input int code);
    expQ.push_back(code);
    modelHist.push_front(code);
    if (modelHist.size() > HD) void'(modelHist.pop_back());
  endfunction

  function automatic logic [6*HD-1:0] histVec();
    logic [6*HD-1:0] v;
    int c;
    v = '0;
    for (int k = 0; k < modelHist.size(); k++) begin
      c = modelHist[k];
      v[6*k +: 6] = c[5:0];
    end
    return v;
  endfunction

  task automatic waitTicks(input int n);
    repeat (n * TICK_DIV) @(negedge CLK);
  endtask

  task automatic keyLetter(input string pat, input int dotT, input int dashT,
                           input int gapT, input int endGapT);
    for (int i = 0; i < pat.len(); i++) begin
      button = 1'b0;
      waitTicks((pat[i] == 8'h2D) ? dashT : dotT);
      button = 1'b1;
      waitTicks((i == pat.len() - 1) ? endGapT : gapT);
    end
  endtask

  task automatic compareStream(input string name);
    total++;
    if (obsQ.size() != expQ.size()) begin
      bad++;
      $display("[TB] FAIL %s count: got %0d codes, expected %0d", name, obsQ.size(), expQ.size());
    end
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      total++;
      if (obsQ[i] !== expQ[i]) begin
        bad++;
        $display("[TB] FAIL %s code[%0d]: got %0d, expected %0d", name, i, obsQ[i], expQ[i]);
      end
    end
    total++;
    if (history !== histVec()) begin
      bad++;
      $display("[TB] FAIL %s history: got %h, expected %h", name, history, histVec());
    end
    total++;
    if (dblCnt !== 0) begin
      bad++;
      $display("[TB] FAIL %s pulse width: got %0d long pulses, expected 0", name, dblCnt);
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (char_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset char_valid: got %b, expected 0", char_valid); end
    total++; if (char_code !== 6'd0) begin bad++; $display("[TB] FAIL reset char_code: got %0d, expected 0", char_code); end
    total++; if (history !== '0) begin bad++; $display("[TB] FAIL reset history: got %h, expected 0", history); end
    total++; if ({dot_led, dash_led, busy} !== 3'b000) begin bad++; $display("[TB] FAIL reset leds/busy: got %b, expected 000", {dot_led, dash_led, busy}); end
  endtask

  task automatic test_letter_e();
    obsQ.delete(); expQ.delete();
    button = 1'b0;
    waitTicks(2);
    #2;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_press: got %b, expected 1", busy); end
    button = 1'b1;
    waitTicks(6);
    #2;
    modelEmit(5);
    total++; if (obsQ.size() !== 1) begin bad++; $display("[TB] FAIL e_pulses: got %0d, expected 1", obsQ.size()); end
    total++; if (char_code !== 6'd5) begin bad++; $display("[TB] FAIL e_code: got %0d, expected 5", char_code); end
    total++; if (history[5:0] !== 6'd5) begin bad++; $display("[TB] FAIL e_hist0: got %0d, expected 5", history[5:0]); end
    total++; if ({dot_led, dash_led} !== 2'b10) begin bad++; $display("[TB] FAIL e_leds: got %b, expected 10", {dot_led, dash_led}); end
    waitTicks(10);
    #2;
    modelEmit(37);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_idle: got %b, expected 0", busy); end
    compareStream("letter_e");
  endtask

  task automatic test_a_space();
    obsQ.delete(); expQ.delete();
    keyLetter(".-", 2, 6, 2, 20);
    modelEmit(1); modelEmit(37);
    waitTicks(20);
    #2;
    compareStream("a_space");
    total++; if ({dot_led, dash_led} !== 2'b01) begin bad++; $display("[TB] FAIL a_leds: got %b, expected 01", {dot_led, dash_led}); end
    total++; if (char_code !== 6'd37) begin bad++; $display("[TB] FAIL a_hold: got %0d, expected 37", char_code); end
  endtask

  task automatic test_overflow();
    obsQ.delete(); expQ.delete();
    keyLetter("......", 2, 6, 2, 6);
    #2;
    modelEmit(63);
    total++; if (obsQ.size() !== 1) begin bad++; $display("[TB] FAIL ovf_pulses: got %0d, expected 1", obsQ.size()); end
    total++; if (history !== histVec()) begin bad++; $display("[TB] FAIL ovf_hist: got %h, expected %h", history, histVec()); end
    waitTicks(10);
    modelEmit(37);
    compareStream("overflow");
  endtask

  task automatic test_digit();
    obsQ.delete(); expQ.delete();
    keyLetter(".----", 2, 6, 2, 16);
    modelEmit(DIGITS ? 28 : 63); modelEmit(37);
    #2;
    compareStream("digit");
  endtask

  task automatic test_back_to_back();
    obsQ.delete(); expQ.delete();
    for (int i = 0; i < 9; i++) begin
      keyLetter(".", 2, 6, 2, 6);
      modelEmit(5);
    end
    #2;
    total++; if (history !== {HD{6'd5}}) begin bad++; $display("[TB] FAIL hist_nine_e: got %h, expected %h", history, {HD{6'd5}}); end
    waitTicks(10);
    modelEmit(37);
    compareStream("back_to_back");
  endtask

  task automatic test_reset_mid();
    obsQ.delete(); expQ.delete();
    button = 1'b0; waitTicks(2);
    button = 1'b1; waitTicks(2);
    button = 1'b0; waitTicks(1);
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    total++; if ({char_valid, char_code, dot_led, dash_led, busy} !== 10'd0) begin
      bad++; $display("[TB] FAIL midreset outputs: got %b, expected 0", {char_valid, char_code, dot_led, dash_led, busy});
    end
    total++; if (history !== '0) begin bad++; $display("[TB] FAIL midreset history: got %h, expected 0", history); end
    button = 1'b1;
    RST_N = 1'b1;
    modelHist.delete();
    waitTicks(20);
    #2;
    total++; if (obsQ.size() !== 0) begin bad++; $display("[TB] FAIL midreset emission: got %0d codes, expected 0", obsQ.size()); end
    keyLetter(".", 2, 6, 2, 16);
    modelEmit(5); modelEmit(37);
    #2;
    compareStream("reset_mid");
  endtask

  task automatic test_random();
    string pat;
    int len, code, endGap;
    bit lastDash;
    obsQ.delete(); expQ.delete();
    lastDash = 1'b0;
    for (int l = 0; l < 24; l++) begin
      if ($urandom_range(0, 4) != 0) begin
        pat = morseTab[$urandom_range(0, 35)];
      end else begin
        pat = "";
        len = $urandom_range(1, 6);
        for (int e = 0; e < len; e++) pat = {pat, ($urandom_range(0, 1) != 0) ? "-" : "."};
      end
      endGap = ($urandom_range(0, 2) == 0) ? $urandom_range(14, 18) : $urandom_range(6, 10);
      if (l == 23) endGap = 16;
      keyLetter(pat, $urandom_range(1, 3), $urandom_range(6, 8), $urandom_range(1, 3), endGap);
      code = modelDecode(pat);
      modelEmit(code);
      if (endGap >= 14) modelEmit(37);
      lastDash = (pat[pat.len() - 1] == 8'h2D);
    end
    #2;
    compareStream("random");
    total++; if ({dot_led, dash_led} !== {~lastDash, lastDash}) begin
      bad++; $display("[TB] FAIL random_leds: got %b, expected %b", {dot_led, dash_led}, {~lastDash, lastDash});
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    button = 1'b1;
    repeat (5) @(negedge CLK);
    test_reset();
    RST_N = 1'b1;
    test_letter_e();
    test_a_space();
    test_overflow();
    test_digit();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
